booth_r16_seq_enc: RTL and testbench
====================================

// Module: booth_r16_seq_enc
// PURPOSE
// Sequential radix-16 Booth recoder: the producer end of the booth_sel/neg_value interface consumed by pp_gen.
// Accepts one multiplier per input handshake.
// Emits its Booth digits serially, least-significant first, one per output handshake.
// Feeds an iterative multiplier datapath that builds one partial product per cycle.
// PARAMETERS
// W       mul_pkg::WIDTH  multiplier operand width (>=4)
// ND      derived         localparam = signed_in ? ceil(W/4) : floor(W/4)+1; sized for worst case floor(W/4)+1
// PORTS
// clk            in   1            system clock, rising edge
// rst            in   1            asynchronous reset, active-high
// flush          in   1            synchronous abort; drops current operand
// in_valid       in   1            multiplier_in/signed_in valid
// in_ready       out  1            encoder can accept an operand
// multiplier_in  in   W            multiplier operand
// signed_in      in   1            1: two's-complement operand; 0: unsigned
// out_valid      out  1            digit outputs valid
// out_ready      in   1            consumer (pp_gen stage) accepts digit
// booth_sel      out  booth_sel_t  digit magnitude PP_0..PP_8A
// neg_value      out  1            digit sign (1 = negative)
// digit_idx      out  $clog2(ND+1) index of current digit (weight 16^idx)
// last           out  1            current digit is the final one of this operand
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; out_valid=0, in_ready=1, booth_sel=PP_0, neg_value=0, digit_idx=0, last=0.
// - FSM states:
//   - IDLE: in_ready=1, out_valid=0. On in_valid:
//     - load shift reg {ext_bits, multiplier_in, 1'b0}; ext = sign bit if signed_in, else 0.
//     - latch ndig; go to EMIT.
//   - EMIT: out_valid=1; outputs decoded from shift reg [4:0] (window b[4i+3:4i-1]).
//   - Digit handshake (out_valid && out_ready):
//     - if !last: shift reg >>= 4 (arithmetic, ext fill); digit_idx++.
//     - if last: return to IDLE.
// - Digit value = -8*b3 + 4*b2 + 2*b1 + b0 + b(-1), range -8..+8.
//   - booth_sel = |value|; neg_value = value<0.
//   - Zero is canonical: PP_0 with neg_value=0, including windows 00000 and 11111.
// - last = (digit_idx == ndig-1).
// - Latency: first digit valid 1 cycle after input handshake.
//   - Full throughput: ND cycles per operand when out_ready is held high.
// - Back-to-back operands: in_ready = IDLE || (out_valid && out_ready && last).
//   - Accepting on the last-digit cycle loads the new operand and stays in EMIT with digit_idx=0; no bubble.
// - Stall: while out_valid && !out_ready, all outputs and the shift reg hold stable.
// - flush: next state IDLE, out_valid=0, digit_idx=0. flush wins over a simultaneous in_valid; no operand is captured.
// - Async reset mid-operand: the operand is discarded; no partial sequence resumes after reset deasserts.
// - in_valid while busy (not last handshake) is ignored; in_ready=0 backpressures.
// - Correctness invariant: sum(digit_i * 16^i) == multiplier_in, interpreted signed/unsigned per signed_in.
// STRUCTURE
// - mul_pkg additions:
//   - booth_win_t (logic [4:0]).
//   - function booth_nd(W, signed) returning the digit count.
//   - enc_state_t {ENC_IDLE, ENC_EMIT}.
//   - Reuse existing booth_sel_t.
// - Sub-module booth_r16_digit (combinational):
//   - booth_win_t in -> booth_sel_t booth_sel, neg_value.
//   - Shared with any future parallel encoder.
// - Top holds FSM, shift register, digit counter, and ndig register.
// TESTING (bench at W=8)
// - 0x77 unsigned -> 3 digits: (PP_7A,+), (PP_7A,+), (PP_0,+); last on idx 2.
// - 0xFF unsigned -> (PP_A,neg=1), (PP_0,neg=0), (PP_A,+); sum -1+0+256=255.
// - 0x80 signed -> 2 digits: (PP_0,+), (PP_8A,neg=1); last on idx 1.
// - 0x88 unsigned, out_ready toggled 1/0 each cycle -> (PP_8A,-), (PP_7A,-), (PP_A,+); outputs stable during stalls.
// - Back-to-back: 0x01 then 0x10, in_valid held, out_ready=1 -> 6 consecutive valid digits, no bubble, in_ready pulses on each last.
// - flush asserted at idx 1 of 0x77 -> out_valid=0 next cycle.
//   - Next operand 0x02 restarts at idx 0: (PP_2A,+)...
// - Also: random sweep of all 256 values x signed_in with scoreboard on the correctness invariant.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared multiplier types: Booth digit magnitudes, recoder window, encoder FSM states.
package mul_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [3:0] {
    PP_0  = 4'd0,
    PP_A  = 4'd1,
    PP_2A = 4'd2,
    PP_3A = 4'd3,
    PP_4A = 4'd4,
    PP_5A = 4'd5,
    PP_6A = 4'd6,
    PP_7A = 4'd7,
    PP_8A = 4'd8
  } booth_sel_t;

  typedef logic [4:0] booth_win_t;

  typedef enum logic {ENC_IDLE, ENC_EMIT} enc_state_t;

  // Signed operands need no extra top digit; unsigned ones need one to absorb the top carry.
  function automatic int booth_nd(input int w, input logic sgn);
    return sgn ? (w + 3) / 4 : w / 4 + 1;
  endfunction

endpackage

// File: rtl/booth_r16_digit.sv
// Radix-16 Booth digit decode of one 5-bit window {b3,b2,b1,b0,b(-1)}.
module booth_r16_digit
  import mul_pkg::*;
(
  input  booth_win_t win,
  output booth_sel_t booth_sel,
  output logic       neg_value
);

  logic signed [5:0] val;
  logic        [3:0] mag;

  // -8*b3 + 4*b2 + 2*b1 + b0 is win[4:1] read as signed; b(-1) adds on top.
  assign val       = $signed({{2{win[4]}}, win[4:1]}) + $signed({5'b0, win[0]});
  assign neg_value = val[5];
  assign mag       = neg_value ? 4'(-val) : val[3:0];
  assign booth_sel = booth_sel_t'(mag);

endmodule

// File: rtl/booth_r16_seq_enc.sv
// Sequential radix-16 Booth recoder: one operand in, its digits out LSB-first, one per handshake.
module booth_r16_seq_enc
  import mul_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [W-1:0]                           multiplier_in,
  input  logic                                   signed_in,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output booth_sel_t                             booth_sel,
  output logic                                   neg_value,
  output logic [$clog2(booth_nd(W, 1'b0)+1)-1:0] digit_idx,
  output logic                                   last
);

  localparam int NDMAX = booth_nd(W, 1'b0);
  localparam int SRW   = 4 * NDMAX + 1;
  localparam int EXTW  = SRW - W - 1;
  localparam int DW    = $clog2(NDMAX + 1);
  localparam logic [DW-1:0] ND_U = DW'(booth_nd(W, 1'b0));
  localparam logic [DW-1:0] ND_S = DW'(booth_nd(W, 1'b1));

  enc_state_t     state, state_n;
  logic [SRW-1:0] sr, sr_n, load_sr;
  logic [DW-1:0]  idx_n, ndig_q, ndig_n;
  logic           hs, load;
  booth_sel_t     dec_sel;
  logic           dec_neg;

  booth_r16_digit u_digit (
    .win       (sr[4:0]),
    .booth_sel (dec_sel),
    .neg_value (dec_neg)
  );

  assign out_valid = (state == ENC_EMIT);
  assign last      = out_valid && (digit_idx == ndig_q - 1'b1);
  assign hs        = out_valid && out_ready;
  assign in_ready  = (state == ENC_IDLE) || (hs && last);
  assign load      = in_ready && in_valid && !flush;
  assign load_sr   = {{EXTW{signed_in & multiplier_in[W-1]}}, multiplier_in, 1'b0};

  // Gate the decode so an idle encoder presents a canonical zero digit.
  assign booth_sel = out_valid ? dec_sel : PP_0;
  assign neg_value = out_valid & dec_neg;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    idx_n   = digit_idx;
    ndig_n  = ndig_q;
    if (flush) begin
      state_n = ENC_IDLE;
      idx_n   = '0;
    end else if (load) begin
      // Also covers the last-digit cycle: next operand follows with no bubble.
      state_n = ENC_EMIT;
      sr_n    = load_sr;
      idx_n   = '0;
      ndig_n  = signed_in ? ND_S : ND_U;
    end else if (hs) begin
      if (last) begin
        state_n = ENC_IDLE;
        idx_n   = '0;
      end else begin
        sr_n  = {{4{sr[SRW-1]}}, sr[SRW-1:4]};
        idx_n = digit_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENC_IDLE;
      sr        <= '0;
      digit_idx <= '0;
      ndig_q    <= '0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      digit_idx <= idx_n;
      ndig_q    <= ndig_n;
    end
  end

endmodule

// File: tb/tb_booth_r16_seq_enc.sv
// Directed and sweep checks of the sequential radix-16 Booth recoder at W=8.
module tb_booth_r16_seq_enc;
  import mul_pkg::*;

  logic       clk = 1'b0;
  logic       rst, flush, in_valid, in_ready, signed_in;
  logic [7:0] multiplier_in;
  logic       out_valid, out_ready, neg_value, last;
  booth_sel_t booth_sel;
  logic [1:0] digit_idx;

  int n_cmp = 0;
  int n_err = 0;

  booth_r16_seq_enc #(.W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .multiplier_in (multiplier_in),
    .signed_in     (signed_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .booth_sel     (booth_sel),
    .neg_value     (neg_value),
    .digit_idx     (digit_idx),
    .last          (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packs {out_valid, sel, neg, idx, last} for one-shot digit comparisons.
  function automatic int pk(input int ov, input int sel, input int ng, input int idx, input int lst);
    return (ov << 8) | (sel << 4) | (ng << 3) | (idx << 1) | lst;
  endfunction

  function automatic int obs();
    return pk(int'(out_valid), int'(booth_sel), int'(neg_value), int'(digit_idx), int'(last));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_op(input logic [7:0] v, input logic s);
    int k;
    multiplier_in = v;
    signed_in     = s;
    in_valid      = 1'b1;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    if (!in_ready) chk("load_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Expected digits per directed case: {sel, neg, idx, last}.
  int d77 [3][4] = '{'{7,0,0,0}, '{7,0,1,0}, '{0,0,2,1}};
  int dff [3][4] = '{'{1,1,0,0}, '{0,0,1,0}, '{1,0,2,1}};
  int d80 [2][4] = '{'{0,0,0,0}, '{8,1,1,1}};
  int d88 [3][4] = '{'{8,1,0,0}, '{7,1,1,0}, '{1,0,2,1}};
  int dbb [6][5] = '{'{1,0,0,0,0}, '{0,0,1,0,0}, '{0,0,2,1,1},
                     '{0,0,0,0,0}, '{1,0,1,0,0}, '{0,0,2,1,1}};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; signed_in = 1'b0;
    multiplier_in = '0; out_ready = 1'b1;
    #3;
    chk("rst_digit", obs(), pk(0,0,0,0,0));
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    load_op(8'h77, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u77_d%0d", i), obs(), pk(1, d77[i][0], d77[i][1], d77[i][2], d77[i][3]));
      tick();
    end
    chk("u77_done", int'(out_valid), 0);

    load_op(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("uFF_d%0d", i), obs(), pk(1, dff[i][0], dff[i][1], dff[i][2], dff[i][3]));
      tick();
    end
    chk("uFF_done", int'(out_valid), 0);

    load_op(8'h80, 1'b1);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("s80_d%0d", i), obs(), pk(1, d80[i][0], d80[i][1], d80[i][2], d80[i][3]));
      tick();
    end
    chk("s80_done", int'(out_valid), 0);

    // Stall every other cycle: digit must hold across the stalled edge.
    load_op(8'h88, 1'b0);
    for (int i = 0; i < 3; i++) begin
      out_ready = 1'b0;
      chk($sformatf("u88_d%0d", i), obs(), pk(1, d88[i][0], d88[i][1], d88[i][2], d88[i][3]));
      tick();
      chk($sformatf("u88_hold%0d", i), obs(), pk(1, d88[i][0], d88[i][1], d88[i][2], d88[i][3]));
      out_ready = 1'b1;
      tick();
    end
    chk("u88_done", int'(out_valid), 0);

    // Back-to-back operands with no bubble between them.
    multiplier_in = 8'h01; signed_in = 1'b0; in_valid = 1'b1;
    tick();
    multiplier_in = 8'h10;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("b2b_d%0d", i), obs(), pk(1, dbb[i][0], dbb[i][1], dbb[i][2], dbb[i][3]));
      chk($sformatf("b2b_rdy%0d", i), int'(in_ready), dbb[i][4]);
      tick();
      if (i == 2) in_valid = 1'b0;
    end
    chk("b2b_done", int'(out_valid), 0);

    // Flush mid-operand, then a fresh operand starts at index 0.
    load_op(8'h77, 1'b0);
    chk("fl_d0", obs(), pk(1,7,0,0,0));
    tick();
    chk("fl_d1", obs(), pk(1,7,0,1,0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_idle", obs(), pk(0,0,0,0,0));
    load_op(8'h02, 1'b0);
    chk("fl_next_d0", obs(), pk(1,2,0,0,0));
    tick(); tick(); tick();
    chk("fl_next_done", int'(out_valid), 0);

    // Flush beats a simultaneous input handshake.
    multiplier_in = 8'h55; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_vs_in", int'(out_valid), 0);

    // Async reset mid-operand discards it.
    load_op(8'h77, 1'b0);
    tick();
    #2 rst = 1'b1;
    #1 chk("arst_now", obs(), pk(0,0,0,0,0));
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    chk("arst_after", int'(out_valid), 0);

    // Sweep every operand in both modes; rebuild the value from its digits.
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 256; v++) begin
        int  sum, n, exp_v, dv;
        bit  done;
        sum = 0; n = 0; done = 1'b0;
        out_ready = 1'b1;
        load_op(8'(v), 1'(s));
        for (int c = 0; c < 64 && !done; c++) begin
          out_ready = 1'($urandom_range(0, 1));
          if (out_valid && out_ready) begin
            dv  = neg_value ? -int'(booth_sel) : int'(booth_sel);
            sum = sum + dv * (1 << (4 * int'(digit_idx)));
            n++;
            if (last) done = 1'b1;
          end
          tick();
        end
        if (!done) chk($sformatf("sweep_timeout_%0d_%0d", s, v), 0, 1);
        exp_v = (s == 1 && v > 127) ? v - 256 : v;
        chk($sformatf("sweep_sum_%0d_%0h", s, v), sum, exp_v);
        chk($sformatf("sweep_nd_%0d_%0h", s, v), n, (s == 1) ? 2 : 3);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
